decode_queue: RTL and testbench

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue.sv | 82 ++++++++
 tb/tb_decode_queue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// Module      : decode_queue
// Description : Fetch-to-decode instruction FIFO holding address/word pairs,
//               with a synchronous flush and an asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    if_valid,
    input  logic [ADDR_WIDTH-1:0]   if_instruction_addr,
    input  logic [DATA_WIDTH-1:0]   if_instruction,
    output logic                    if_ready,
    output logic                    dec_valid,
    output logic [ADDR_WIDTH-1:0]   dec_instruction_addr,
    output logic [DATA_WIDTH-1:0]   dec_instruction,
    input  logic                    dec_ready,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;

    assign w_empty   = (r_count == '0);
    // Readiness is based on the registered count only, so a pop never frees a slot in the same cycle.
    assign if_ready  = !rst && (r_count < c_DEPTH_CNT) && !flush;
    assign dec_valid = !w_empty && !flush;
    assign w_push    = if_valid && if_ready;
    assign w_pop     = dec_valid && dec_ready;

    assign dec_instruction_addr = w_empty ? '0 : r_addr_mem[r_rd_ptr];
    assign dec_instruction      = w_empty ? '0 : r_data_mem[r_rd_ptr];
    assign count                = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr_mem[i] <= '0;
                r_data_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_addr_mem[r_wr_ptr] <= if_instruction_addr;
                r_data_mem[r_wr_ptr] <= if_instruction;
                r_wr_ptr             <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_queue
// Description : Scoreboard bench for decode_queue against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_queue;

    localparam int c_DEPTH = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] word;
    } entry_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_instruction_addr;
    logic [31:0] if_instruction;
    logic        if_ready;
    logic        dec_valid;
    logic [31:0] dec_instruction_addr;
    logic [31:0] dec_instruction;
    logic        dec_ready;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    entry_t exp_q[$];

    decode_queue #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (c_DEPTH)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush                (flush),
        .if_valid             (if_valid),
        .if_instruction_addr  (if_instruction_addr),
        .if_instruction       (if_instruction),
        .if_ready             (if_ready),
        .dec_valid            (dec_valid),
        .dec_instruction_addr (dec_instruction_addr),
        .dec_instruction      (dec_instruction),
        .dec_ready            (dec_ready),
        .count                (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of entries; pop is decided before push so a full queue stays closed.
    always @(posedge clk) begin
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            automatic bit m_pop  = (exp_q.size() != 0) && dec_ready;
            automatic bit m_push = if_valid && (exp_q.size() < c_DEPTH);
            if (m_pop)  void'(exp_q.pop_front());
            if (m_push) exp_q.push_back({if_instruction_addr, if_instruction});
        end
    end

    // Monitor: compares every DUT output against the model away from the active edge.
    always @(negedge clk) begin
        automatic entry_t head = (exp_q.size() != 0) ? exp_q[0] : '0;
        check("count",     64'(count),     64'(exp_q.size()));
        check("if_ready",  64'(if_ready),  64'(!rst && exp_q.size() < c_DEPTH && !flush));
        check("dec_valid", 64'(dec_valid), 64'(exp_q.size() != 0 && !flush));
        check("head_addr", 64'(dec_instruction_addr), 64'(head.addr));
        check("head_word", 64'(dec_instruction),      64'(head.word));
    end

    task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic r, input logic f);
        if_valid            = v;
        if_instruction_addr = a;
        if_instruction      = d;
        dec_ready           = r;
        flush               = f;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_valid  = 1'b0;
        dec_ready = 1'b0;
        flush     = 1'b0;
        #0;
    endtask

    logic [31:0] words [4];

    initial begin
        words[0] = 32'h0000_0013;
        words[1] = 32'h0010_0093;
        words[2] = 32'h0020_0113;
        words[3] = 32'h0030_0193;
        rst = 1'b1;
        flush = 1'b0;
        if_valid = 1'b0;
        dec_ready = 1'b0;
        if_instruction_addr = '0;
        if_instruction = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_if_ready", 64'(if_ready), 64'(0));
        check("rst_count",    64'(count),    64'(0));
        rst = 1'b0;
        #1;
        check("post_rst_if_ready", 64'(if_ready), 64'(1));

        // Fill to full with no consumer.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'(4 * i), words[i], 1'b0, 1'b0);
        idle();
        check("full_count",    64'(count),                64'(4));
        check("full_if_ready", 64'(if_ready),             64'(0));
        check("full_head",     64'(dec_instruction_addr), 64'h0);
        check("full_word",     64'(dec_instruction),      64'h0000_0013);

        // Pop from full while pushing: only the pop happens.
        cyc(1'b1, 32'h10, 32'h0040_0213, 1'b1, 1'b0);
        idle();
        check("pop_full_count", 64'(count),                64'(3));
        check("pop_full_head",  64'(dec_instruction_addr), 64'h4);
        cyc(1'b1, 32'h10, 32'h0040_0213, 1'b0, 1'b0);
        idle();
        check("refill_count", 64'(count), 64'(4));
        repeat (4) cyc(1'b0, '0, '0, 1'b1, 1'b0);
        idle();
        check("drained_count", 64'(count), 64'(0));

        // Continuous streaming across pointer wrap.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 32'(4 * i), $urandom, 1'b1, 1'b0);
            check("stream_count_le1", 64'(count <= 3'd1), 64'(1));
        end
        cyc(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush overriding simultaneous push and pop.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'(32'h40 + 4 * i), $urandom, 1'b0, 1'b0);
        cyc(1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 1'b1);
        idle();
        check("flush_count",     64'(count),     64'(0));
        check("flush_dec_valid", 64'(dec_valid), 64'(0));
        cyc(1'b1, 32'h200, 32'h1234_5678, 1'b0, 1'b0);
        idle();
        check("after_flush_head", 64'(dec_instruction_addr), 64'h200);

        // Asynchronous reset between edges with two entries queued.
        cyc(1'b1, 32'h204, 32'h0000_0033, 1'b0, 1'b0);
        idle();
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("async_count",     64'(count),                64'(0));
        check("async_dec_valid", 64'(dec_valid),            64'(0));
        check("async_addr",      64'(dec_instruction_addr), 64'(0));
        check("async_word",      64'(dec_instruction),      64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("release_if_ready", 64'(if_ready), 64'(1));

        // Pops on an empty queue are ignored.
        repeat (5) cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("empty_pop_count", 64'(count), 64'(0));
        cyc(1'b1, 32'h300, 32'h0000_0073, 1'b0, 1'b0);
        idle();
        check("empty_pop_head", 64'(dec_instruction_addr), 64'h300);

        // Randomized traffic; the monitor and model carry the checking.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 4) != 0, $urandom, $urandom, ($urandom % 3) != 0, ($urandom % 25) == 0);
        end
        idle();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
